// File: rtl/m_ext_issue_ctrl.sv
// M-extension issue controller: accepts one mul/div op, latches its operands
// for the M ALU, waits for done or a watchdog timeout, and holds the result
// until the consumer takes it.
// Optional one-entry result reuse cache: define M_RESULT_REUSE_EN.
module m_ext_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        alu_active_o,
  output logic [31:0] alu_rs1_o,
  output logic [31:0] alu_rs2_o,
  output logic [2:0]  alu_funct3_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_rd_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  input  logic        rsp_ready_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q, op_in;
  logic [31:0]      rsp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
  logic             accept, done_take, tmo_hit, cache_hit;
  logic [31:0]      hit_data;

  assign op_in  = {funct3_i, rs1_data_i, rs2_data_i};
  // flush wins over acceptance in the same cycle
  assign accept = (state == IDLE) && req_valid_i && !flush_i;

`ifdef M_RESULT_REUSE_EN
  logic        cache_vld;
  op_t         cache_key;
  logic [31:0] cache_res;

  assign cache_hit = cache_vld && (cache_key == op_in);
  assign hit_data  = cache_res;

  // record only genuine ALU completions; timeouts and flushed ops never fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_res <= '0;
    end else if (done_take) begin
      cache_vld <= 1'b1;
      cache_key <= op_q;
      cache_res <= alu_rd_data_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; done is only meaningful in BUSY since an idle ALU reports done
  always_comb begin
    state_nxt = state;
    done_take = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = cache_hit ? RESP : BUSY;
      BUSY: begin
        if (flush_i) state_nxt = IDLE;
        else if (alu_done_i) begin
          done_take = 1'b1;
          state_nxt = RESP;
        end else if (cnt_q == CNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: if (flush_i || rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, watchdog counter, response data and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rsp_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op_in;
        cnt_q <= '0;
        if (cache_hit) rsp_q <= hit_data;
      end else if (state == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done_take) rsp_q <= alu_rd_data_i;
      if (tmo_hit) begin
        rsp_q <= 32'hFFFF_FFFF;
        tmo_q <= 1'b1;
      end
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign alu_active_o = (state == BUSY);
  assign rsp_valid_o  = (state == RESP);
  assign busy_o       = (state != IDLE);
  assign alu_funct3_o = op_q.funct3;
  assign alu_rs1_o    = op_q.rs1;
  assign alu_rs2_o    = op_q.rs2;
  assign rsp_data_o   = rsp_q;
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_m_ext_issue_ctrl.sv
// Directed bench for m_ext_issue_ctrl with a behavioural M ALU and a
// scoreboard of expected responses. Reuse-cache checks follow M_RESULT_REUSE_EN.
module tb_m_ext_issue_ctrl;
  localparam int TMO = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid_i = 1'b0, flush_i = 1'b0, rsp_ready_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0;
  logic        req_ready_o, alu_active_o, alu_done_i, rsp_valid_o, busy_o, timeout_o;
  logic [31:0] alu_rs1_o, alu_rs2_o, alu_rd_data_i, rsp_data_o;
  logic [2:0]  alu_funct3_o;

  always #5 clk = ~clk;

  m_ext_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .alu_active_o(alu_active_o), .alu_rs1_o(alu_rs1_o), .alu_rs2_o(alu_rs2_o),
    .alu_funct3_o(alu_funct3_o), .alu_done_i(alu_done_i), .alu_rd_data_i(alu_rd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // behavioural M ALU: done whenever idle, otherwise after lat active cycles
  int lat = 3;
  bit hang = 1'b0;
  int acnt = 0;

  function automatic logic [31:0] alu_f(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk) acnt <= alu_active_o ? acnt + 1 : 0;
  always_comb begin
    alu_done_i    = alu_active_o ? (!hang && acnt >= lat - 1) : 1'b1;
    alu_rd_data_i = alu_f(alu_funct3_o, alu_rs1_o, alu_rs2_o);
  end

  // cycle counter and activity monitor (sampled at the active edge: prior-cycle values)
  int cyc = 0, act_cnt = 0, done_cyc = -1, inact_run = 0, last_gap = -1;
  bit prev_act = 1'b0, seen_act = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_active_o) begin
      act_cnt <= act_cnt + 1;
      if (alu_done_i) done_cyc <= cyc;
      if (!prev_act && seen_act) last_gap <= inact_run;
      seen_act  <= 1'b1;
      inact_run <= 0;
    end else begin
      inact_run <= inact_run + 1;
    end
    prev_act <= alu_active_o;
  end

  int nvec = 0, nerr = 0;
  int acc_cyc = 0, rsp_cyc = 0, a0 = 0, l = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit push);
    chk("ready_before_issue", 64'(req_ready_o), 64'd1);
    funct3_i = f; rs1_data_i = a; rs2_data_i = b; req_valid_i = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    req_valid_i = 1'b0;
    funct3_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom;
    acc_cyc = cyc;
    chk("op_latched", 64'({alu_funct3_o, alu_rs1_o, alu_rs2_o}), 64'({f, a, b}));
  endtask

  task automatic get_rsp(input string tag, input int hold, output int lat_seen);
    int n;
    logic [31:0] e;
    n = 0;
    while (!rsp_valid_o && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
    rsp_cyc  = cyc;
    lat_seen = cyc - acc_cyc;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk({tag, "_data"}, 64'(rsp_data_o), 64'(e));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, 64'({rsp_valid_o, rsp_data_o}), 64'({1'b1, e}));
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk({tag, "_idle"}, 64'({busy_o, rsp_valid_o, req_ready_o}), 64'(3'b001));
  endtask

  initial begin
    bit sawv;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({busy_o, alu_active_o, rsp_valid_o, timeout_o, req_ready_o}), 64'(5'b00001));
    chk("rst_data", 64'(rsp_data_o), 64'd0);
    chk("rst_ops", 64'({alu_funct3_o, alu_rs1_o, alu_rs2_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MUL 6*7, ALU latency 3
    lat = 3; a0 = act_cnt;
    issue(3'b000, 32'd6, 32'd7, 32'd42, 1'b1);
    get_rsp("mul", 0, l);
    chk("mul_active_cycles", 64'(act_cnt - a0), 64'd3);
    chk("mul_valid_after_done", 64'(rsp_cyc - done_cyc), 64'd1);
    chk("mul_latency", 64'(l), 64'd3);

    // DIV 100/7 held under backpressure, then REM 100/7
    lat = 2;
    issue(3'b100, 32'd100, 32'd7, 32'd14, 1'b1);
    get_rsp("div", 4, l);
    issue(3'b110, 32'd100, 32'd7, 32'd2, 1'b1);
    get_rsp("rem", 0, l);
    chk("inactive_gap", 64'(last_gap >= 1), 64'd1);

    // flush on the 2nd BUSY cycle of DIVU
    lat = 6;
    issue(3'b101, 32'd50, 32'd3, 32'd0, 1'b0);
    chk("divu_busy1", 64'({busy_o, alu_active_o}), 64'(2'b11));
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_idle", 64'({busy_o, rsp_valid_o, alu_active_o, req_ready_o}), 64'(4'b0001));
    sawv = 1'b0;
    repeat (3) begin @(negedge clk); sawv |= rsp_valid_o; end
    chk("flush_no_rsp", 64'(sawv), 64'd0);
    lat = 2;
    issue(3'b000, 32'd3, 32'd5, 32'd15, 1'b1);
    get_rsp("mul_after_flush", 0, l);

    // watchdog: ALU never finishes
    hang = 1'b1; a0 = act_cnt;
    issue(3'b000, 32'd9, 32'd9, 32'hFFFF_FFFF, 1'b1);
    chk("tmo_clear_early", 64'(timeout_o), 64'd0);
    get_rsp("tmo", 0, l);
    chk("tmo_busy_cycles", 64'(act_cnt - a0), 64'(TMO));
    chk("tmo_latency", 64'(l), 64'(TMO));
    chk("tmo_sticky", 64'(timeout_o), 64'd1);
    hang = 1'b0;

    // MULHU FFFF_FFFF*2 twice
    lat = 2; a0 = act_cnt;
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1);
    get_rsp("mulhu1", 0, l);
    chk("mulhu1_active", 64'(act_cnt - a0), 64'd2);
    a0 = act_cnt;
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1);
    get_rsp("mulhu2", 0, l);
`ifdef M_RESULT_REUSE_EN
    chk("mulhu2_reuse_active", 64'(act_cnt - a0), 64'd0);
    chk("mulhu2_reuse_latency", 64'(l), 64'd0);
`else
    chk("mulhu2_active", 64'(act_cnt - a0), 64'd2);
    chk("mulhu2_latency", 64'(l), 64'd2);
`endif

    // asynchronous reset mid-BUSY
    lat = 6;
    issue(3'b000, 32'd2, 32'd2, 32'd4, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", 64'({busy_o, alu_active_o, rsp_valid_o, timeout_o, req_ready_o}), 64'(5'b00001));
    chk("arst_data", 64'(rsp_data_o), 64'd0);
    chk("arst_ops", 64'({alu_funct3_o, alu_rs1_o, alu_rs2_o}), 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // after reset the reuse entry is gone, so this goes through the ALU
    lat = 2; a0 = act_cnt;
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1);
    get_rsp("post_rst", 0, l);
    chk("post_rst_active", 64'(act_cnt - a0), 64'd2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/m_ext_issue_ctrl.md
M_EXT_ISSUE_CTRL -- requirements
Module: m_ext_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum number of BUSY cycles before the watchdog fires.
REQ-002 SHALL have ports `clk` (in, 1) and `rst` (in, 1): one clock; reset is asynchronous and active-high.
REQ-003 SHALL have the request-side ports:
- req_valid_i (in, 1): request offered.
- req_ready_o (out, 1): controller can accept.
- funct3_i (in, 3): M-op encoding, 000 mul to 111 remu.
- rs1_data_i (in, 32) and rs2_data_i (in, 32): operands.
- flush_i (in, 1): kill in-flight work.
REQ-004 SHALL have the ALU-side ports:
- alu_active_o (out, 1): enable to the M ALU.
- alu_rs1_o (out, 32), alu_rs2_o (out, 32), alu_funct3_o (out, 3): latched operands and op.
- alu_done_i (in, 1): ALU done.
- alu_rd_data_i (in, 32): ALU result.
REQ-005 SHALL have the response-side ports:
- rsp_valid_o (out, 1): result available.
- rsp_data_o (out, 32): result.
- rsp_ready_i (in, 1): consumer takes result.
- busy_o (out, 1): state is not IDLE.
- timeout_o (out, 1): sticky watchdog flag.

Function
REQ-006 SHALL implement three states, IDLE, BUSY and RESP, with req_ready_o=1 only in IDLE.
REQ-007 SHALL accept a request on a rising edge with req_valid_i & req_ready_o & ~flush_i, latching funct3_i, rs1_data_i and rs2_data_i into registers that drive the alu_* operand outputs, and go to BUSY.
REQ-008 SHALL drive alu_active_o=1 only in BUSY; in IDLE and RESP it SHALL be 0, which guarantees at least one inactive cycle between consecutive ops so the ALU restarts.
REQ-009 SHALL sample alu_done_i only in BUSY, because the ALU reports done=1 whenever it is inactive.
REQ-010 SHALL, on alu_done_i=1 in BUSY, capture alu_rd_data_i into rsp_data_o and go to RESP, so rsp_valid_o rises the cycle after done.
REQ-011 SHALL hold rsp_valid_o=1 and a stable rsp_data_o in RESP until rsp_ready_i=1, then return to IDLE; a new request can be accepted no earlier than the following cycle.
REQ-012 SHALL return to IDLE on flush_i=1 in BUSY or RESP, discarding the op or response with no rsp_valid_o; flush_i has priority over alu_done_i, rsp_ready_i and acceptance in the same cycle.
REQ-013 SHALL count BUSY cycles with a counter cleared on entry to BUSY; when the count reaches TIMEOUT_CYCLES it SHALL set timeout_o (sticky until reset), return rsp_data_o=32'hFFFF_FFFF through RESP, and deassert alu_active_o.
REQ-014 SHALL keep the latched operands and op unchanged from acceptance until return to IDLE.
REQ-015 SHALL drive busy_o = (state != IDLE).

Reset
REQ-016 SHALL, on asynchronous rst assertion, go to IDLE with alu_active_o=0, rsp_valid_o=0, rsp_data_o=0, the operand/op registers=0, counter=0, timeout_o=0 and the reuse entry invalid, abandoning any op mid-flight.
REQ-017 SHALL accept its first request no earlier than the first edge after rst deasserts.

Configuration
REQ-018 SHALL provide a one-entry reuse cache compiled in only when macro M_RESULT_REUSE_EN is defined.
REQ-019 SHALL, with M_RESULT_REUSE_EN, record {funct3, rs1, rs2, result} on each BUSY->RESP transition that is neither a timeout nor flushed; an accepted request matching a valid entry SHALL go directly to RESP with the cached result, rsp_valid_o one cycle after acceptance, and alu_active_o never asserted.
REQ-020 SHALL, without M_RESULT_REUSE_EN, contain no cache storage, so every accepted request passes through BUSY.

Verification
REQ-021 SHALL have a bench covering: MUL, funct3=000, rs1=6, rs2=7, ALU model latency 3 -> alu_active_o high 3 cycles, rsp_data_o=42, rsp_valid_o rises the cycle after done.
REQ-022 SHALL have a bench covering: DIV 100/7 then REM 100/7 with rsp_ready_i held low 4 cycles -> 14 held stable, then 2; alu_active_o low for at least 1 cycle between ops.
REQ-023 SHALL have a bench covering: flush_i asserted on the 2nd BUSY cycle of DIVU -> IDLE next cycle, no rsp_valid_o, next MUL 3*5 returns 15.
REQ-024 SHALL have a bench covering: ALU model never asserts done, TIMEOUT_CYCLES=8 -> after 8 BUSY cycles timeout_o=1 and rsp_data_o=FFFF_FFFF.
REQ-025 SHALL have a bench covering: with M_RESULT_REUSE_EN, MULHU FFFF_FFFF*2 issued twice -> both return 1; the second has rsp_valid_o one cycle after acceptance and no alu_active_o pulse.
REQ-026 SHALL have a bench covering: rst asserted mid-BUSY -> all outputs at reset values immediately, without waiting for a clock edge.
